// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller with IR, IDCODE/DTMCS/BYPASS data registers and
// the DMI shift-path hookup for the RISC-V debug transport module.
module jtag_tap_ctrl #(
    parameter int unsigned IrLength    = 5,
    parameter logic [31:0] IdcodeValue = 32'h00000001
) (
    input  logic       tck_i,
    input  logic       trst_ni,
    input  logic       tms_i,
    input  logic       td_i,
    output logic       td_o,
    output logic       tdo_oe_o,
    input  logic       testmode_i,
    output logic       test_logic_reset_o,
    output logic       shift_dr_o,
    output logic       update_dr_o,
    output logic       capture_dr_o,
    output logic       dmi_access_o,
    output logic       dtmcs_select_o,
    output logic       dmi_reset_o,
    input  logic [1:0] dmi_error_i,
    output logic       dmi_tdi_o,
    input  logic       dmi_tdo_i
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } tap_state_e;

    localparam logic [IrLength-1:0] IR_IDCODE = IrLength'(5'h01);
    localparam logic [IrLength-1:0] IR_DTMCS  = IrLength'(5'h10);
    localparam logic [IrLength-1:0] IR_DMI    = IrLength'(5'h11);

    tap_state_e          state_q, state_d;
    logic [IrLength-1:0] ir_q, ir_d;
    logic [IrLength-1:0] ir_shift_q, ir_shift_d;
    logic [31:0]         idcode_q, idcode_d;
    logic [31:0]         dtmcs_q, dtmcs_d;
    logic                bypass_q, bypass_d;
    logic                td_o_q, td_o_d;
    logic                tdo_oe_q, tdo_oe_d;

    logic idcode_select;
    logic bypass_select;
    logic dr_tdo;
    logic tck_n;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:      state_d = tms_i ? TLR      : RTI;
            RTI:      state_d = tms_i ? SEL_DR   : RTI;
            SEL_DR:   state_d = tms_i ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = tms_i ? EX1_DR   : SH_DR;
            SH_DR:    state_d = tms_i ? EX1_DR   : SH_DR;
            EX1_DR:   state_d = tms_i ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = tms_i ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_d = tms_i ? UPD_DR   : SH_DR;
            UPD_DR:   state_d = tms_i ? SEL_DR   : RTI;
            SEL_IR:   state_d = tms_i ? TLR      : CAP_IR;
            CAP_IR:   state_d = tms_i ? EX1_IR   : SH_IR;
            SH_IR:    state_d = tms_i ? EX1_IR   : SH_IR;
            EX1_IR:   state_d = tms_i ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = tms_i ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_d = tms_i ? UPD_IR   : SH_IR;
            UPD_IR:   state_d = tms_i ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    assign test_logic_reset_o = (state_q == TLR);
    assign shift_dr_o         = (state_q == SH_DR);
    assign update_dr_o        = (state_q == UPD_DR);
    assign capture_dr_o       = (state_q == CAP_DR);

    assign idcode_select  = (ir_q == IR_IDCODE);
    assign dtmcs_select_o = (ir_q == IR_DTMCS);
    assign dmi_access_o   = (ir_q == IR_DMI);
    assign bypass_select  = !(idcode_select || dtmcs_select_o || dmi_access_o);

    assign dmi_tdi_o   = td_i;
    assign dmi_reset_o = dtmcs_select_o & update_dr_o & dtmcs_q[16];

    always_comb begin
        ir_d       = ir_q;
        ir_shift_d = ir_shift_q;
        unique case (state_q)
            TLR:     ir_d       = IR_IDCODE;
            CAP_IR:  ir_shift_d = IrLength'(1);
            SH_IR:   ir_shift_d = {td_i, ir_shift_q[IrLength-1:1]};
            UPD_IR:  ir_d       = ir_shift_q;
            default: ;
        endcase
    end

    // Only the register picked by the current IR captures or shifts.
    always_comb begin
        idcode_d = idcode_q;
        dtmcs_d  = dtmcs_q;
        bypass_d = bypass_q;
        if (state_q == CAP_DR) begin
            if (idcode_select)  idcode_d = IdcodeValue;
            if (dtmcs_select_o) dtmcs_d  = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1,
                                            dmi_error_i, 6'd7, 4'd1};
            if (bypass_select)  bypass_d = 1'b0;
        end else if (state_q == SH_DR) begin
            if (idcode_select)  idcode_d = {td_i, idcode_q[31:1]};
            if (dtmcs_select_o) dtmcs_d  = {td_i, dtmcs_q[31:1]};
            if (bypass_select)  bypass_d = td_i;
        end
    end

    always_comb begin
        dr_tdo = bypass_q;
        if (dmi_access_o)        dr_tdo = dmi_tdo_i;
        else if (idcode_select)  dr_tdo = idcode_q[0];
        else if (dtmcs_select_o) dr_tdo = dtmcs_q[0];
    end

    always_comb begin
        td_o_d   = 1'b0;
        tdo_oe_d = (state_q == SH_IR) || (state_q == SH_DR);
        if (state_q == SH_IR)      td_o_d = ir_shift_q[0];
        else if (state_q == SH_DR) td_o_d = dr_tdo;
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q    <= TLR;
            ir_q       <= IR_IDCODE;
            ir_shift_q <= '0;
            idcode_q   <= '0;
            dtmcs_q    <= '0;
            bypass_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_shift_q <= ir_shift_d;
            idcode_q   <= idcode_d;
            dtmcs_q    <= dtmcs_d;
            bypass_q   <= bypass_d;
        end
    end

    // TDO launches on the falling edge; scan mode keeps every flop on the true clock.
    assign tck_n = testmode_i ? tck_i : ~tck_i;

    always_ff @(posedge tck_n or negedge trst_ni) begin
        if (!trst_ni) begin
            td_o_q   <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            td_o_q   <= td_o_d;
            tdo_oe_q <= tdo_oe_d;
        end
    end

    assign td_o     = td_o_q;
    assign tdo_oe_o = tdo_oe_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: table-driven TAP model, queue-based IR
// model and scan-level expected words derived from the register definitions.
module tb_jtag_tap_ctrl;

    localparam logic [31:0] IDCODE = 32'h00000001;

    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                   PDR = 6, EX2DR = 7, UDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11,
                   EX1IR = 12, PIR = 13, EX2IR = 14, UIR = 15;

    logic       tck_i = 1'b0;
    logic       trst_ni;
    logic       tms_i;
    logic       td_i;
    logic       td_o;
    logic       tdo_oe_o;
    logic       testmode_i;
    logic       test_logic_reset_o;
    logic       shift_dr_o;
    logic       update_dr_o;
    logic       capture_dr_o;
    logic       dmi_access_o;
    logic       dtmcs_select_o;
    logic       dmi_reset_o;
    logic [1:0] dmi_error_i;
    logic       dmi_tdi_o;
    logic       dmi_tdo_i;

    jtag_tap_ctrl #(.IrLength(5), .IdcodeValue(IDCODE)) dut (
        .tck_i              (tck_i),
        .trst_ni            (trst_ni),
        .tms_i              (tms_i),
        .td_i               (td_i),
        .td_o               (td_o),
        .tdo_oe_o           (tdo_oe_o),
        .testmode_i         (testmode_i),
        .test_logic_reset_o (test_logic_reset_o),
        .shift_dr_o         (shift_dr_o),
        .update_dr_o        (update_dr_o),
        .capture_dr_o       (capture_dr_o),
        .dmi_access_o       (dmi_access_o),
        .dtmcs_select_o     (dtmcs_select_o),
        .dmi_reset_o        (dmi_reset_o),
        .dmi_error_i        (dmi_error_i),
        .dmi_tdi_o          (dmi_tdi_o),
        .dmi_tdo_i          (dmi_tdo_i)
    );

    always #5 tck_i = ~tck_i;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int   nxt0 [16];
    int   nxt1 [16];
    int   st;
    int   ir;
    bit   irq[$];
    logic tdo_s, oe_s;
    int   cap_cnt, upd_cnt, rst_cnt;

    function automatic int queue_value();
        int v = 0;
        for (int i = 0; i < irq.size(); i++) v += int'(irq[i]) << i;
        return v;
    endfunction

    task automatic model_reset();
        st  = TLR;
        ir  = 1;
        irq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    endtask

    task automatic tick(input logic tms, input logic tdi, input logic dtdo);
        logic [5:0] act, exp;
        bit         sh;
        tms_i = tms; td_i = tdi; dmi_tdo_i = dtdo;
        #1;
        checks++;
        if (dmi_tdi_o !== tdi) begin
            errors++;
            $display("FAIL dmi_tdi: got %b want %b", dmi_tdi_o, tdi);
        end
        @(posedge tck_i);
        if (st == TLR) ir = 1;
        else if (st == UIR) ir = queue_value();
        if (st == CAPIR) irq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        else if (st == SHIR) begin
            irq.push_back(tdi);
            void'(irq.pop_front());
        end
        st = tms ? nxt1[st] : nxt0[st];
        #1;
        act = {test_logic_reset_o, shift_dr_o, update_dr_o, capture_dr_o,
               dmi_access_o, dtmcs_select_o};
        exp = {st == TLR, st == SHDR, st == UDR, st == CAPDR, ir == 'h11, ir == 'h10};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL strobes: got %b want %b (state %0d ir %0h)", act, exp, st, ir);
        end
        if (capture_dr_o === 1'b1) cap_cnt++;
        if (update_dr_o === 1'b1) upd_cnt++;
        if (dmi_reset_o === 1'b1) rst_cnt++;
        @(negedge tck_i);
        #1;
        tdo_s = td_o;
        oe_s  = tdo_oe_o;
        sh    = (st == SHIR) || (st == SHDR);
        checks++;
        if (oe_s !== sh) begin
            errors++;
            $display("FAIL tdo_oe: got %b want %b (state %0d)", oe_s, sh, st);
        end
        if (!sh) begin
            checks++;
            if (tdo_s !== 1'b0) begin
                errors++;
                $display("FAIL td_o_idle: got %b want 0 (state %0d)", tdo_s, st);
            end
        end
    endtask

    // Full scan from RTI back to RTI; dout collects td_o LSB first.
    task automatic scan(input bit is_ir, input logic [63:0] din, input int n,
                        input logic [63:0] dseq, output logic [63:0] dout,
                        output int oe_n);
        dout = '0;
        oe_n = 0;
        tick(1'b1, 1'b0, 1'b0); oe_n += int'(oe_s);
        if (is_ir) begin tick(1'b1, 1'b0, 1'b0); oe_n += int'(oe_s); end
        tick(1'b0, 1'b0, 1'b0); oe_n += int'(oe_s);
        tick(1'b0, 1'b0, dseq[0]); oe_n += int'(oe_s);
        dout[0] = tdo_s;
        for (int k = 0; k < n; k++) begin
            tick(k == n - 1, din[k], (k < n - 1) ? dseq[k + 1] : 1'b0);
            oe_n += int'(oe_s);
            if (k < n - 1) dout[k + 1] = tdo_s;
        end
        tick(1'b1, 1'b0, 1'b0); oe_n += int'(oe_s);
        tick(1'b0, 1'b0, 1'b0); oe_n += int'(oe_s);
    endtask

    task automatic test_reset();
        logic [8:0] act;
        trst_ni = 1'b0;
        #3;
        act = {test_logic_reset_o, shift_dr_o, update_dr_o, capture_dr_o,
               dmi_access_o, dtmcs_select_o, td_o, tdo_oe_o, dmi_reset_o};
        checks++;
        if (act !== 9'b100000000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", act, 9'b100000000);
        end
        @(negedge tck_i); #1;
        trst_ni = 1'b1;
        model_reset();
        $display("reset: outputs %b", act);
    endtask

    task automatic test_tlr_from_shdr();
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (test_logic_reset_o !== 1'b1 || dmi_access_o !== 1'b0 || dtmcs_select_o !== 1'b0) begin
            errors++;
            $display("FAIL tlr_from_shdr: tlr=%b dmi=%b dtmcs=%b want 1 0 0",
                     test_logic_reset_o, dmi_access_o, dtmcs_select_o);
        end
        tick(1'b0, 1'b0, 1'b0);
        $display("tlr_from_shdr: tlr reached after five TMS=1");
    endtask

    task automatic test_idcode(input string tag);
        logic [63:0] dout;
        int          oe_n;
        scan(1'b0, {32'h0, $urandom}, 32, '0, dout, oe_n);
        checks++;
        if (dout[31:0] !== IDCODE || oe_n != 32) begin
            errors++;
            $display("FAIL idcode_%s: got %h oe=%0d want %h oe=32", tag, dout[31:0], oe_n, IDCODE);
        end
        $display("idcode_%s: read %h, oe cycles %0d", tag, dout[31:0], oe_n);
    endtask

    task automatic set_ir(input logic [4:0] code);
        logic [63:0] dout;
        int          oe_n;
        scan(1'b1, {59'h0, code}, 5, '0, dout, oe_n);
        checks++;
        if (dout[4:0] !== 5'b00001 || oe_n != 5) begin
            errors++;
            $display("FAIL ir_capture: got %b oe=%0d want 00001 oe=5", dout[4:0], oe_n);
        end
        $display("ir_scan: loaded %h, captured out %b", code, dout[4:0]);
    endtask

    task automatic test_ir_dtmcs();
        set_ir(5'h10);
        checks++;
        if (dtmcs_select_o !== 1'b1 || dmi_access_o !== 1'b0) begin
            errors++;
            $display("FAIL ir_dtmcs: dtmcs=%b dmi=%b want 1 0", dtmcs_select_o, dmi_access_o);
        end
    endtask

    task automatic test_dtmcs_read();
        logic [63:0] dout;
        logic [31:0] exp;
        int          oe_n, r0;
        for (int i = 0; i < 4; i++) begin
            dmi_error_i = (i == 0) ? 2'b11 : 2'($urandom_range(0, 3));
            exp = 32'((1 << 12) + (int'(dmi_error_i) << 10) + (7 << 4) + 1);
            r0  = rst_cnt;
            scan(1'b0, {32'h0, $urandom & 32'hFFFE_FFFF}, 32, '0, dout, oe_n);
            checks++;
            if (dout[31:0] !== exp || rst_cnt != r0) begin
                errors++;
                $display("FAIL dtmcs_read: got %h pulses=%0d want %h pulses=0",
                         dout[31:0], rst_cnt - r0, exp);
            end
            $display("dtmcs_read: err=%b word %h", dmi_error_i, dout[31:0]);
        end
    endtask

    task automatic test_dtmcs_write();
        logic [63:0] dout;
        int          oe_n, r0;
        for (int i = 0; i < 2; i++) begin
            logic [31:0] w;
            w = $urandom;
            w[16] = (i == 0);
            r0 = rst_cnt;
            scan(1'b0, {32'h0, w}, 32, '0, dout, oe_n);
            checks++;
            if (rst_cnt - r0 != int'(w[16])) begin
                errors++;
                $display("FAIL dtmcs_write: bit16=%b pulses got %0d want %0d",
                         w[16], rst_cnt - r0, int'(w[16]));
            end
            $display("dtmcs_write: word %h, dmireset pulses %0d", w, rst_cnt - r0);
        end
    endtask

    task automatic test_dmi();
        logic [63:0] dout, din, dseq;
        int          oe_n, c0, u0;
        set_ir(5'h11);
        din  = {$urandom, $urandom};
        dseq = {$urandom, $urandom};
        c0 = cap_cnt; u0 = upd_cnt;
        scan(1'b0, din, 41, dseq, dout, oe_n);
        checks++;
        if (dout[40:0] !== dseq[40:0] || oe_n != 41) begin
            errors++;
            $display("FAIL dmi_tdo: got %h oe=%0d want %h oe=41", dout[40:0], oe_n, dseq[40:0]);
        end
        checks++;
        if (cap_cnt - c0 != 1 || upd_cnt - u0 != 1) begin
            errors++;
            $display("FAIL dmi_strobes: capture %0d update %0d want 1 1", cap_cnt - c0, upd_cnt - u0);
        end
        $display("dmi_scan: tdo word %h", dout[40:0]);
    endtask

    task automatic test_bypass();
        logic [4:0]  codes [3];
        logic [63:0] dout, din, exp;
        int          oe_n;
        codes = '{5'h05, 5'h00, 5'h1F};
        for (int i = 0; i < 3; i++) begin
            set_ir(codes[i]);
            din = {$urandom, $urandom};
            exp = {din[62:0], 1'b0};
            scan(1'b0, din, 24, '0, dout, oe_n);
            checks++;
            if (dout[23:0] !== exp[23:0]) begin
                errors++;
                $display("FAIL bypass_%h: got %h want %h", codes[i], dout[23:0], exp[23:0]);
            end
            $display("bypass ir=%h: out %h", codes[i], dout[23:0]);
        end
    endtask

    task automatic test_trst_mid_shift();
        logic [4:0] act;
        set_ir(5'h10);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'($urandom), 1'b0);
        checks++;
        if (tdo_oe_o !== 1'b1 || dtmcs_select_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_trst: oe=%b dtmcs=%b want 1 1", tdo_oe_o, dtmcs_select_o);
        end
        trst_ni = 1'b0;
        #1;
        act = {test_logic_reset_o, td_o, tdo_oe_o, dtmcs_select_o, dmi_access_o};
        checks++;
        if (act !== 5'b10000) begin
            errors++;
            $display("FAIL trst_mid_shift: got %b want 10000", act);
        end
        $display("trst_mid_shift: outputs %b", act);
        @(negedge tck_i); #1;
        trst_ni = 1'b1;
        model_reset();
        tick(1'b0, 1'b0, 1'b0);
        test_idcode("after_trst");
    endtask

    task automatic test_random_walk();
        for (int i = 0; i < 400; i++)
            tick(1'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (test_logic_reset_o !== 1'b1) begin
            errors++;
            $display("FAIL random_walk_tlr: got %b want 1", test_logic_reset_o);
        end
        $display("random_walk: 400 cycles, ir=%0h", ir);
    endtask

    initial begin
        nxt0 = '{RTI, RTI, CAPDR, SHDR, SHDR, PDR, PDR, SHDR, RTI,
                 CAPIR, SHIR, SHIR, PIR, PIR, SHIR, RTI};
        nxt1 = '{TLR, SELDR, SELIR, EX1DR, EX1DR, UDR, EX2DR, UDR, SELDR,
                 TLR, EX1IR, EX1IR, UIR, EX2IR, UIR, SELDR};
        cap_cnt = 0; upd_cnt = 0; rst_cnt = 0;
        tms_i = 1'b1; td_i = 1'b0; dmi_tdo_i = 1'b0;
        testmode_i = 1'b0; dmi_error_i = 2'b00;
        model_reset();
        test_reset();
        test_tlr_from_shdr();
        test_idcode("first");
        test_ir_dtmcs();
        test_dtmcs_read();
        test_dtmcs_write();
        test_dmi();
        test_bypass();
        test_trst_mid_shift();
        test_random_walk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
